// File: rtl/maxpool_2_mram_writer.sv
// 2x2/stride-2 signed max-pool writer: pools a row-major conv-2 pixel stream and packs results into MRAM port-A words.
// Build option: define MAXPOOL2_RELU_EN to clamp negative pooled values to zero before packing.
module maxpool_2_mram_writer #(
    parameter int         IN_W      = 26,
    parameter int         IN_H      = 26,
    parameter int         CHANNELS  = 8,
    parameter logic [9:0] BASE_ADDR = 10'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [9:0]  mram_addr_a,
    output logic [31:0] mram_din_a,
    output logic        mram_en_a,
    output logic [3:0]  mram_we_a,
    output logic        busy,
    output logic        done,
    output logic [15:0] out_count
);

    localparam int CW       = $clog2(IN_W);
    localparam int RW       = $clog2(IN_H);
    localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int LB_DEPTH = IN_W / 2;
    localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [CW-1:0]  COL_LAST = CW'(IN_W - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(IN_H - 1);
    localparam logic [CHW-1:0] CH_LAST  = CHW'(CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [CHW-1:0]    ch;
    logic [1:0]        lane;
    logic [9:0]        word_idx;
    logic [23:0]       pack;
    logic signed [7:0] h_reg;
    logic signed [7:0] lbuf [LB_DEPTH];

    logic              accept;
    logic              emit;
    logic              last_pix;
    logic [LBW-1:0]    lb_idx;
    logic signed [7:0] pix;
    logic signed [7:0] h_max;
    logic signed [7:0] pool_raw;
    logic [7:0]        pooled;
    logic [1:0]        lane_next;

    function automatic logic signed [7:0] smax(input logic signed [7:0] a,
                                               input logic signed [7:0] b);
        return (a > b) ? a : b;
    endfunction

    // pix_ready is high exactly while in RUN, so it doubles as the handshake gate.
    assign accept    = pix_valid && pix_ready;
    assign pix       = signed'(pix_in);
    assign lb_idx    = LBW'(col >> 1);
    assign h_max     = smax(h_reg, pix);
    assign pool_raw  = smax(lbuf[lb_idx], h_max);
    assign emit      = accept && row[0] && col[0];
    assign last_pix  = (col == COL_LAST) && (row == ROW_LAST) && (ch == CH_LAST);
    assign lane_next = emit ? lane + 2'd1 : lane;

`ifdef MAXPOOL2_RELU_EN
    assign pooled = pool_raw[7] ? 8'd0 : pool_raw;
`else
    assign pooled = pool_raw;
`endif

    // Even rows stash the horizontal pair max; odd rows read it back at the same column pair.
    always_ff @(posedge clk) begin
        if (accept && !row[0] && col[0]) begin
            lbuf[lb_idx] <= h_max;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_IDLE;
            col         <= '0;
            row         <= '0;
            ch          <= '0;
            lane        <= 2'd0;
            word_idx    <= 10'd0;
            pack        <= 24'd0;
            h_reg       <= 8'sd0;
            pix_ready   <= 1'b0;
            mram_addr_a <= 10'd0;
            mram_din_a  <= 32'd0;
            mram_en_a   <= 1'b0;
            mram_we_a   <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            out_count   <= 16'd0;
        end else begin
            mram_en_a <= 1'b0;
            mram_we_a <= 4'd0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RUN;
                        col       <= '0;
                        row       <= '0;
                        ch        <= '0;
                        lane      <= 2'd0;
                        word_idx  <= 10'd0;
                        pack      <= 24'd0;
                        out_count <= 16'd0;
                        pix_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                S_RUN: begin
                    if (accept) begin
                        if (!col[0]) begin
                            h_reg <= pix;
                        end

                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row <= '0;
                                ch  <= ch + CHW'(1);
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end

                        if (emit) begin
                            out_count <= out_count + 16'd1;
                            lane      <= lane_next;
                            case (lane)
                                2'd0: pack[7:0]   <= pooled;
                                2'd1: pack[15:8]  <= pooled;
                                2'd2: pack[23:16] <= pooled;
                                default: begin
                                    mram_en_a   <= 1'b1;
                                    mram_we_a   <= 4'hF;
                                    mram_addr_a <= BASE_ADDR + word_idx;
                                    mram_din_a  <= {pooled, pack};
                                    word_idx    <= word_idx + 10'd1;
                                    pack        <= 24'd0;
                                end
                            endcase
                        end

                        if (last_pix) begin
                            pix_ready <= 1'b0;
                            if (lane_next != 2'd0) begin
                                state <= S_FLUSH;
                            end else begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end

                S_FLUSH: begin
                    // Unfilled lanes of pack are already zero because pack is cleared after each full word.
                    mram_en_a   <= 1'b1;
                    mram_addr_a <= BASE_ADDR + word_idx;
                    mram_din_a  <= {8'd0, pack};
                    case (lane)
                        2'd1:    mram_we_a <= 4'b0001;
                        2'd2:    mram_we_a <= 4'b0011;
                        default: mram_we_a <= 4'b0111;
                    endcase
                    word_idx <= word_idx + 10'd1;
                    lane     <= 2'd0;
                    pack     <= 24'd0;
                    state    <= S_DONE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_2_mram_writer.sv
// Bench for maxpool_2_mram_writer: four configurations share one pixel bus, a window-max model feeds the write scoreboard.
module tb_maxpool_2_mram_writer;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  pix_in = 8'd0;
    logic        pix_valid = 1'b0;
    logic        start_v [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic        ready_v [4];
    logic [9:0]  addr_v  [4];
    logic [31:0] din_v   [4];
    logic        en_v    [4];
    logic [3:0]  we_v    [4];
    logic        busy_v  [4];
    logic        done_v  [4];
    logic [15:0] cnt_v   [4];

    // Configurations: 0 = 4x4x1, 1 = 4x4x2, 2 = 6x2x1 at 0x3FF, 3 = 5x5x1
    int          cfg_w    [4] = '{4, 4, 6, 5};
    int          cfg_h    [4] = '{4, 4, 2, 5};
    int          cfg_c    [4] = '{1, 2, 1, 1};
    logic [9:0]  cfg_base [4] = '{10'd0, 10'd0, 10'h3FF, 10'd0};

    maxpool_2_mram_writer #(.IN_W(4), .IN_H(4), .CHANNELS(1), .BASE_ADDR(10'd0)) u_w4h4c1 (
        .clk(clk), .resetn(resetn), .start(start_v[0]), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(ready_v[0]), .mram_addr_a(addr_v[0]), .mram_din_a(din_v[0]), .mram_en_a(en_v[0]),
        .mram_we_a(we_v[0]), .busy(busy_v[0]), .done(done_v[0]), .out_count(cnt_v[0]));

    maxpool_2_mram_writer #(.IN_W(4), .IN_H(4), .CHANNELS(2), .BASE_ADDR(10'd0)) u_w4h4c2 (
        .clk(clk), .resetn(resetn), .start(start_v[1]), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(ready_v[1]), .mram_addr_a(addr_v[1]), .mram_din_a(din_v[1]), .mram_en_a(en_v[1]),
        .mram_we_a(we_v[1]), .busy(busy_v[1]), .done(done_v[1]), .out_count(cnt_v[1]));

    maxpool_2_mram_writer #(.IN_W(6), .IN_H(2), .CHANNELS(1), .BASE_ADDR(10'h3FF)) u_w6h2c1 (
        .clk(clk), .resetn(resetn), .start(start_v[2]), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(ready_v[2]), .mram_addr_a(addr_v[2]), .mram_din_a(din_v[2]), .mram_en_a(en_v[2]),
        .mram_we_a(we_v[2]), .busy(busy_v[2]), .done(done_v[2]), .out_count(cnt_v[2]));

    maxpool_2_mram_writer #(.IN_W(5), .IN_H(5), .CHANNELS(1), .BASE_ADDR(10'd0)) u_w5h5c1 (
        .clk(clk), .resetn(resetn), .start(start_v[3]), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(ready_v[3]), .mram_addr_a(addr_v[3]), .mram_din_a(din_v[3]), .mram_en_a(en_v[3]),
        .mram_we_a(we_v[3]), .busy(busy_v[3]), .done(done_v[3]), .out_count(cnt_v[3]));

    logic [1:0]  sel = 2'd0;
    logic        s_ready, s_en, s_busy, s_done;
    logic [9:0]  s_addr;
    logic [31:0] s_din;
    logic [3:0]  s_we;
    logic [15:0] s_cnt;

    always_comb begin
        s_ready = ready_v[sel];
        s_addr  = addr_v[sel];
        s_din   = din_v[sel];
        s_en    = en_v[sel];
        s_we    = we_v[sel];
        s_busy  = busy_v[sel];
        s_done  = done_v[sel];
        s_cnt   = cnt_v[sel];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // Scoreboard entries are {addr[9:0], din[31:0], we[3:0]}.
    logic [45:0] exp_q [$];
    logic [7:0]  fr [64];
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] first_din = 32'd0;
    logic        mon_on = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (s_en) begin
                logic [45:0] e;
                wr_cnt++;
                if (wr_cnt == 1) first_din = s_din;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", {22'd0, s_addr}, {22'd0, e[45:36]});
                    check("wr_din", s_din, e[35:4]);
                    check("wr_we", {28'd0, s_we}, {28'd0, e[3:0]});
                end
            end
            if (s_done) done_cnt++;
        end
    end

    function automatic logic [7:0] relu(input logic [7:0] v);
`ifdef MAXPOOL2_RELU_EN
        return v[7] ? 8'd0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [7:0] bmax(input logic [7:0] a, input logic [7:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    // Reference: direct 2x2 window maxima over the stored frame, floor-pooled.
    task automatic build_expect(input int s);
        int w, h, c, k, base;
        logic [9:0]  a;
        logic [31:0] word;
        logic [7:0]  m;
        w = cfg_w[s]; h = cfg_h[s]; c = cfg_c[s];
        a = cfg_base[s]; k = 0; word = 32'd0;
        for (int ci = 0; ci < c; ci++) begin
            for (int r = 0; r < h / 2; r++) begin
                for (int cc = 0; cc < w / 2; cc++) begin
                    base = ci * w * h + 2 * r * w + 2 * cc;
                    m = bmax(bmax(fr[base], fr[base + 1]), bmax(fr[base + w], fr[base + w + 1]));
                    word = word | ({24'd0, relu(m)} << (8 * (k % 4)));
                    k++;
                    if (k % 4 == 0) begin
                        exp_q.push_back({a, word, 4'hF});
                        a = a + 10'd1;
                        word = 32'd0;
                    end
                end
            end
        end
        if (k % 4 != 0) exp_q.push_back({a, word, 4'((1 << (k % 4)) - 1)});
    endtask

    task automatic pulse_start(input logic [1:0] s);
        @(posedge clk); #1;
        start_v[s] = 1'b1;
        @(posedge clk); #1;
        start_v[s] = 1'b0;
    endtask

    // gap: 0 = back-to-back, 1 = valid every other cycle, 2 = random idle gaps
    task automatic drive_pixels(input int n, input int gap, output logic ok);
        int g;
        logic acc;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            g = (gap == 1) ? ((i > 0) ? 1 : 0) : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (g) begin
                pix_valid = 1'b0;
                pix_in = 8'($urandom_range(0, 255));
                @(posedge clk); #1;
            end
            pix_valid = 1'b1;
            pix_in = fr[i];
            acc = 1'b0;
            for (int t = 0; t < 50 && !acc; t++) begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk); #1;
            end
            if (!acc) begin
                ok = 1'b0;
                pix_valid = 1'b0;
                return;
            end
        end
        pix_valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  sel;
        int          pat;      // 0 = ramp, 1 = all -3 with pixel 5 = -1, 2 = random
        int          gap;
        logic [15:0] exp_cnt;
        int          exp_writes;
        logic        chk_din0;
        logic [31:0] exp_din0;
    } vec_t;

`ifdef MAXPOOL2_RELU_EN
    localparam logic [31:0] NEG_DIN = 32'h00000000;
`else
    localparam logic [31:0] NEG_DIN = 32'hFDFDFDFF;
`endif

    task automatic fill_frame(input logic [1:0] s, input int pat);
        for (int i = 0; i < 64; i++) begin
            case (pat)
                0:       fr[i] = 8'(i);
                1:       fr[i] = (i == 5) ? 8'hFF : 8'hFD;
                default: fr[i] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic run_frame(input vec_t v);
        logic ok;
        int n;
        sel = v.sel;
        fill_frame(v.sel, v.pat);
        n = cfg_w[v.sel] * cfg_h[v.sel] * cfg_c[v.sel];
        exp_q.delete();
        build_expect(v.sel);
        wr_cnt = 0; done_cnt = 0; first_din = 32'd0;
        pulse_start(v.sel);
        drive_pixels(n, v.gap, ok);
        if (!ok) begin
            fail_now("pixel_accept_timeout");
        end else begin
            for (int i = 0; i < 20 && done_cnt == 0; i++) @(negedge clk);
            repeat (4) @(negedge clk);
            check("done_pulses", 32'(done_cnt), 32'd1);
            check("write_count", 32'(wr_cnt), 32'(v.exp_writes));
            check("out_count", {16'd0, s_cnt}, {16'd0, v.exp_cnt});
            check("queue_drained", 32'(exp_q.size()), 32'd0);
            check("idle_flags", {29'd0, s_busy, s_ready, s_en}, 32'd0);
            if (v.chk_din0) check("first_din", first_din, v.exp_din0);
        end
        exp_q.delete();
    endtask

    vec_t vecs [8];

    initial begin
        logic ok;
        vecs[0] = '{2'd0, 0, 0, 16'd4, 1, 1'b1, 32'h0F0D0705};
        vecs[1] = '{2'd0, 1, 0, 16'd4, 1, 1'b1, NEG_DIN};
        vecs[2] = '{2'd2, 0, 0, 16'd3, 1, 1'b1, 32'h000B0907};
        vecs[3] = '{2'd1, 0, 1, 16'd8, 2, 1'b1, 32'h0F0D0705};
        vecs[4] = '{2'd3, 0, 0, 16'd4, 1, 1'b1, 32'h12100806};
        vecs[5] = '{2'd0, 2, 2, 16'd4, 1, 1'b0, 32'd0};
        vecs[6] = '{2'd3, 2, 2, 16'd4, 1, 1'b0, 32'd0};
        vecs[7] = '{2'd1, 2, 2, 16'd8, 2, 1'b0, 32'd0};

        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            check("rst_flags", {27'd0, en_v[s], busy_v[s], done_v[s], ready_v[s], |we_v[s]}, 32'd0);
            check("rst_addr", {22'd0, addr_v[s]}, 32'd0);
            check("rst_din", din_v[s], 32'd0);
            check("rst_count", {16'd0, cnt_v[s]}, 32'd0);
        end
        mon_on = 1'b1;

        for (int i = 0; i < 8; i++) run_frame(vecs[i]);

        // Reset mid-frame: 10 of 16 pixels, then a one-cycle reset must discard everything.
        sel = 2'd0;
        fill_frame(2'd0, 0);
        exp_q.delete();
        wr_cnt = 0; done_cnt = 0;
        pulse_start(2'd0);
        drive_pixels(10, 0, ok);
        if (!ok) fail_now("partial_accept_timeout");
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("midrst_flags", {27'd0, s_en, s_busy, s_done, s_ready, |s_we}, 32'd0);
        check("midrst_addr_din", {22'd0, s_addr} | s_din, 32'd0);
        check("midrst_count", {16'd0, s_cnt}, 32'd0);
        repeat (4) @(negedge clk);
        check("midrst_no_write", 32'(wr_cnt), 32'd0);
        run_frame(vecs[0]);

        mon_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
